demux3_3_reg: RTL and testbench

- Registered 1-to-3 demultiplexer, the write-side counterpart of the 3-input, 3-bit selector (MUX3_3) in the 8-bit datapath.
- Steers one LARGURA-bit value into one of three holding registers, chosen by the same 2-bit Controle encoding the selector uses.
- Each channel has a valid flag and a consume handshake, so a downstream MUX3_3 can later read back whatever was written.
- Fed by the same Controle, MUX3_3 returns exactly the value last written to that channel.

---
 rtl/demux3_3_reg.sv | 44 ++++
 tb/tb_demux3_3_reg.sv | 91 +++++++++
 2 files changed

// File: rtl/demux3_3_reg.sv
// demux3_3_reg: registered 1-to-3 demux with per-channel valid/consume and overflow tracking
module demux3_3_reg #(
  parameter int LARGURA = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [LARGURA-1:0] Entrada,
  input  logic [1:0]         Controle,
  input  logic               Escrever,
  input  logic [2:0]         Consumir,
  output logic [LARGURA-1:0] Saida0,
  output logic [LARGURA-1:0] Saida1,
  output logic [LARGURA-1:0] Saida2,
  output logic [2:0]         Valido,
  output logic               Descartado,
  output logic               Erro
);
  logic [2:0] sel, wr, acc, we;
  logic drop;
  always_comb begin
    sel  = Controle == 2'b00 ? 3'b001 : Controle == 2'b01 ? 3'b010 : 3'b100;
    wr   = Escrever ? sel : 3'b000;
    acc  = ~Valido | Consumir;
    we   = wr & acc;
    drop = |(wr & ~acc);
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Saida0     <= '0;
      Saida1     <= '0;
      Saida2     <= '0;
      Valido     <= 3'b000;
      Descartado <= 1'b0;
      Erro       <= 1'b0;
    end else begin
      Saida0     <= we[0] ? Entrada : Saida0;
      Saida1     <= we[1] ? Entrada : Saida1;
      Saida2     <= we[2] ? Entrada : Saida2;
      Valido     <= (Valido & ~Consumir) | we;
      Descartado <= drop;
      Erro       <= Erro | drop;
    end
  end
endmodule

// File: tb/tb_demux3_3_reg.sv
// tb_demux3_3_reg: table-driven scoreboard bench for demux3_3_reg
module tb_demux3_3_reg;
  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] Entrada = '0;
  logic [1:0] Controle = '0;
  logic       Escrever = 1'b0;
  logic [2:0] Consumir = '0;
  logic [2:0] Saida0, Saida1, Saida2, Valido;
  logic       Descartado, Erro;
  demux3_3_reg #(.LARGURA(3)) dut (
    .Clock(Clock), .Reset(Reset), .Entrada(Entrada), .Controle(Controle),
    .Escrever(Escrever), .Consumir(Consumir), .Saida0(Saida0), .Saida1(Saida1),
    .Saida2(Saida2), .Valido(Valido), .Descartado(Descartado), .Erro(Erro)
  );
  always #5 Clock = ~Clock;
  typedef struct {
    logic       rst;
    logic [1:0] ctl;
    logic       esc;
    logic [2:0] ent;
    logic [2:0] cons;
    logic [2:0] s0, s1, s2, val;
    logic       desc, erro;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  int total = 0;
  int fails = 0;
  task automatic chk(input string n, input logic [2:0] a, input logic [2:0] e);
    total++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b want %b", n, a, e);
    end
  endtask
  task automatic run(input int lo, input int hi);
    vec_t v, x;
    for (int i = lo; i <= hi; i++) begin
      v = tbl[i];
      @(negedge Clock);
      Reset = v.rst; Controle = v.ctl; Escrever = v.esc; Entrada = v.ent; Consumir = v.cons;
      sb.push_back(v);
      @(posedge Clock);
      #1;
      x = sb.pop_front();
      chk($sformatf("v%0d Saida0", i), Saida0, x.s0);
      chk($sformatf("v%0d Saida1", i), Saida1, x.s1);
      chk($sformatf("v%0d Saida2", i), Saida2, x.s2);
      chk($sformatf("v%0d Valido", i), Valido, x.val);
      chk($sformatf("v%0d Descartado", i), {2'b00, Descartado}, {2'b00, x.desc});
      chk($sformatf("v%0d Erro", i), {2'b00, Erro}, {2'b00, x.erro});
    end
  endtask
  initial begin
    logic [2:0] mux_exp[3];
    logic [2:0] m;
    //             rst ctl   esc ent     cons    s0      s1      s2      val     desc erro
    tbl.push_back('{1, 2'd0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0}); // 0 reset
    tbl.push_back('{0, 2'd0, 1, 3'b111, 3'b000, 3'b111, 3'b000, 3'b000, 3'b001, 0, 0}); // 1
    tbl.push_back('{0, 2'd1, 1, 3'b010, 3'b000, 3'b111, 3'b010, 3'b000, 3'b011, 0, 0}); // 2
    tbl.push_back('{0, 2'd2, 1, 3'b000, 3'b000, 3'b111, 3'b010, 3'b000, 3'b111, 0, 0}); // 3
    tbl.push_back('{0, 2'd1, 1, 3'b110, 3'b000, 3'b111, 3'b010, 3'b000, 3'b111, 1, 1}); // 4 overflow
    for (int k = 0; k < 5; k++)                                                         // 5-9 idle, junk ignored
      tbl.push_back('{0, 2'd1, 0, 3'b101, 3'b000, 3'b111, 3'b010, 3'b000, 3'b111, 0, 1});
    tbl.push_back('{0, 2'd0, 1, 3'b011, 3'b001, 3'b011, 3'b010, 3'b000, 3'b111, 0, 1}); // 10 refill
    tbl.push_back('{0, 2'd0, 0, 3'b000, 3'b010, 3'b011, 3'b010, 3'b000, 3'b101, 0, 1}); // 11 consume
    tbl.push_back('{0, 2'd0, 0, 3'b000, 3'b010, 3'b011, 3'b010, 3'b000, 3'b101, 0, 1}); // 12 no-op
    tbl.push_back('{0, 2'd0, 1, 3'b100, 3'b000, 3'b011, 3'b010, 3'b000, 3'b111, 0, 1}); // 13 refill ch1 -> val
    tbl.push_back('{1, 2'd2, 1, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0}); // 14 reset+write
    tbl.push_back('{0, 2'd3, 1, 3'b101, 3'b000, 3'b000, 3'b000, 3'b101, 3'b100, 0, 0}); // 15 ctl 11
    tbl.push_back('{0, 2'd0, 1, 3'b001, 3'b000, 3'b001, 3'b000, 3'b101, 3'b101, 0, 0}); // 16
    tbl.push_back('{0, 2'd0, 0, 3'b000, 3'b101, 3'b001, 3'b000, 3'b101, 3'b000, 0, 0}); // 17 multi consume
    tbl.push_back('{0, 2'd0, 0, 3'b000, 3'b100, 3'b001, 3'b000, 3'b101, 3'b000, 0, 0}); // 18 no-op
    tbl.push_back('{0, 2'd2, 1, 3'b100, 3'b000, 3'b001, 3'b000, 3'b100, 3'b100, 0, 0}); // 19
    tbl.push_back('{0, 2'd2, 1, 3'b110, 3'b000, 3'b001, 3'b000, 3'b100, 3'b100, 1, 1}); // 20 overflow ch2
    tbl.push_back('{0, 2'd0, 0, 3'b000, 3'b000, 3'b001, 3'b000, 3'b100, 3'b100, 0, 1}); // 21
    // row 13: ch0 valid, no consume -> actually an overflow; fix expectation
    tbl[13] = '{0, 2'd0, 1, 3'b100, 3'b000, 3'b011, 3'b010, 3'b000, 3'b101, 1, 1};
    run(0, 3);
    mux_exp = '{3'b111, 3'b010, 3'b000};
    for (int c = 0; c < 3; c++) begin
      m = c == 0 ? Saida0 : c == 1 ? Saida1 : Saida2;
      chk($sformatf("mux3_3 ctl%0d", c), m, mux_exp[c]);
    end
    run(4, tbl.size() - 1);
    if (sb.size() != 0) chk("scoreboard drain", 3'(sb.size()), 3'd0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
